// File: rtl/mips_debug_pkg.sv
// Shared debug-controller types: FSM state encoding and debug command codes.
package mips_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } step_state_t;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

endpackage

// File: rtl/pipeline_step_ctrl_if.sv
// Debug-unit command handshake into the step controller.
interface pipeline_step_ctrl_if;
  logic       i_cmd_valid;
  logic [1:0] i_cmd;
  logic       o_cmd_ready;

  modport master (output i_cmd_valid, output i_cmd, input o_cmd_ready);
  modport slave  (input i_cmd_valid, input i_cmd, output o_cmd_ready);
endinterface

// File: rtl/step_cycle_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
module step_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Holds at all-ones instead of wrapping so long runs stay readable.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_count <= '0;
    else if (i_en && (r_count != '1))
      r_count <= r_count + WIDTH'(1);
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_step_ctrl.sv
// Run/step/stop sequencer producing the pipeline-wide step enable, with HALT drain.
// Optional build macro STEP_CYCLE_COUNTER_EN enables the step-cycle counter.
module pipeline_step_ctrl
  import mips_debug_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int NB_CYCLE   = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  pipeline_step_ctrl_if.slave cmd_if,
  input  logic                i_halt,
  output logic                o_step,
  output logic                o_done,
  output logic [2:0]          o_state,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH);

  step_state_t   r_state, w_nextState;
  logic [DW-1:0] r_drainCount, w_drainNext;
  logic          w_step, w_ready, w_done, w_accept;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_drainCount <= '0;
    end else begin
      r_state      <= w_nextState;
      r_drainCount <= w_drainNext;
    end
  end

  assign w_accept = cmd_if.i_cmd_valid & w_ready;

  // HALT is only meaningful in stepping states; in RUN it outranks a same-cycle STOP.
  always_comb begin
    w_nextState = r_state;
    w_drainNext = r_drainCount;
    w_step      = 1'b0;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (w_accept && cmd_if.i_cmd == CMD_RUN)
          w_nextState = ST_RUN;
        else if (w_accept && cmd_if.i_cmd == CMD_STEP)
          w_nextState = ST_STEP;
      end
      ST_RUN: begin
        w_step  = 1'b1;
        w_ready = 1'b1;
        if (i_halt) begin
          w_nextState = ST_DRAIN;
          w_drainNext = DRAIN_LOAD;
        end else if (w_accept && cmd_if.i_cmd == CMD_STOP) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_STEP: begin
        w_step = 1'b1;
        if (i_halt) begin
          w_nextState = ST_DRAIN;
          w_drainNext = DRAIN_LOAD;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        w_step = 1'b1;
        if (r_drainCount == DW'(1)) begin
          w_nextState = ST_DONE;
          w_drainNext = '0;
        end else if (r_drainCount != '0) begin
          w_drainNext = r_drainCount - DW'(1);
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_nextState = ST_IDLE;
        w_drainNext = '0;
      end
    endcase
  end

  assign o_step             = w_step;
  assign o_done             = w_done;
  assign o_state            = r_state;
  assign cmd_if.o_cmd_ready = w_ready;

`ifdef STEP_CYCLE_COUNTER_EN
  step_cycle_counter #(
    .WIDTH (NB_CYCLE)
  ) u_step_cycle_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_step),
    .o_count (o_cycle_count)
  );
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Self-checking bench for pipeline_step_ctrl: directed scenarios then random commands,
// compared each cycle against a behavioural model of the run/step/drain rules.
module tb_pipeline_step_ctrl;
  import mips_debug_pkg::*;

  localparam int PIPE_DEPTH = 4;
  localparam int NB_CYCLE   = 4;
  localparam int COUNT_MAX  = (1 << NB_CYCLE) - 1;
`ifdef STEP_CYCLE_COUNTER_EN
  localparam bit COUNTER_EN = 1'b1;
`else
  localparam bit COUNTER_EN = 1'b0;
`endif

  logic                i_clk;
  logic                i_reset;
  logic                i_halt;
  logic                o_step;
  logic                o_done;
  logic [2:0]          o_state;
  logic [NB_CYCLE-1:0] o_cycle_count;

  pipeline_step_ctrl_if cmdBus ();

  pipeline_step_ctrl #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .NB_CYCLE   (NB_CYCLE)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .cmd_if        (cmdBus),
    .i_halt        (i_halt),
    .o_step        (o_step),
    .o_done        (o_done),
    .o_state       (o_state),
    .o_cycle_count (o_cycle_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checkCount = 0;
  int errorCount = 0;

  // Model: what the controller is doing, held as plain flags and a remaining-drain tally.
  bit mRunning   = 0;
  bit mSingle    = 0;
  int mDrainLeft = 0;
  bit mFinished  = 0;
  int mCount     = 0;

  function automatic bit modelStep();
    return !mFinished && (mRunning || mSingle || mDrainLeft > 0);
  endfunction

  function automatic bit modelReady();
    return !mFinished && mDrainLeft == 0 && !mSingle;
  endfunction

  function automatic logic [2:0] modelState();
    if (mFinished)          return 3'd4;
    else if (mDrainLeft > 0) return 3'd3;
    else if (mSingle)       return 3'd2;
    else if (mRunning)      return 3'd1;
    else                    return 3'd0;
  endfunction

  task automatic compareBit(input string tag, input logic obs, input logic exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [2:0]          expState;
    logic [NB_CYCLE-1:0] expCount;
    expState = modelState();
    expCount = COUNTER_EN ? NB_CYCLE'(mCount) : '0;
    compareBit("step",  o_step, modelStep());
    compareBit("ready", cmdBus.o_cmd_ready, modelReady());
    compareBit("done",  o_done, mFinished);
    checkCount++;
    assert (o_state === expState) else begin
      errorCount++;
      $error("[TB] FAIL state observed=%0d expected=%0d at %0t", o_state, expState, $time);
    end
    checkCount++;
    assert (o_cycle_count === expCount) else begin
      errorCount++;
      $error("[TB] FAIL cycle_count observed=%0d expected=%0d at %0t", o_cycle_count, expCount, $time);
    end
  endtask

  // Advances the model across one clock edge using the inputs that were presented.
  task automatic modelEdge(input bit rst, input bit valid, input logic [1:0] cmd, input bit halt);
    bit accepted;
    if (rst) begin
      mRunning = 0; mSingle = 0; mDrainLeft = 0; mFinished = 0; mCount = 0;
      return;
    end
    accepted = valid && modelReady();
    if (modelStep() && mCount < COUNT_MAX) mCount++;
    if (mFinished) begin
    end else if (mDrainLeft > 0) begin
      mDrainLeft--;
      if (mDrainLeft == 0) mFinished = 1;
    end else if (mSingle) begin
      mSingle = 0;
      if (halt) mDrainLeft = PIPE_DEPTH;
    end else if (mRunning) begin
      if (halt) begin
        mRunning = 0;
        mDrainLeft = PIPE_DEPTH;
      end else if (accepted && cmd == CMD_STOP) begin
        mRunning = 0;
      end
    end else if (accepted) begin
      if (cmd == CMD_RUN)  mRunning = 1;
      if (cmd == CMD_STEP) mSingle = 1;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit valid, input logic [1:0] cmd,
                               input bit halt, input bit doCheck = 1'b1);
    i_reset            = rst;
    cmdBus.i_cmd_valid = valid;
    cmdBus.i_cmd       = cmd;
    i_halt             = halt;
    if (doCheck) checkOutput();
    @(posedge i_clk);
    modelEdge(rst, valid, cmd, halt);
    #2;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, CMD_NOP, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_halt = 1'b0;
    cmdBus.i_cmd_valid = 1'b0; cmdBus.i_cmd = CMD_NOP;

    applyStimulus(1, 0, CMD_NOP, 0, 1'b0);
    applyStimulus(1, 0, CMD_NOP, 0);
    idleCycles(2);

    applyStimulus(0, 1, CMD_STEP, 0);
    idleCycles(2);
    applyStimulus(0, 1, CMD_STEP, 1'b0);
    idleCycles(2);

    applyStimulus(1, 0, CMD_NOP, 0);
    applyStimulus(0, 1, CMD_RUN, 0);
    idleCycles(9);
    applyStimulus(0, 1, CMD_STOP, 0);
    idleCycles(3);

    applyStimulus(1, 0, CMD_NOP, 0);
    applyStimulus(0, 1, CMD_RUN, 0);
    idleCycles(4);
    applyStimulus(0, 1, CMD_STOP, 1);
    idleCycles(6);
    applyStimulus(0, 1, CMD_RUN, 0);
    applyStimulus(0, 1, CMD_RUN, 1);
    idleCycles(2);

    applyStimulus(1, 0, CMD_NOP, 0);
    applyStimulus(0, 1, CMD_RUN, 0);
    applyStimulus(0, 0, CMD_NOP, 1);
    applyStimulus(0, 0, CMD_NOP, 0);
    applyStimulus(1, 1, CMD_RUN, 1);
    idleCycles(2);

    applyStimulus(1, 0, CMD_NOP, 0);
    applyStimulus(0, 1, CMD_STEP, 1);
    idleCycles(6);

    applyStimulus(1, 0, CMD_NOP, 0);
    applyStimulus(0, 1, CMD_RUN, 0);
    idleCycles(20);
    applyStimulus(0, 1, CMD_STOP, 0);
    idleCycles(2);

    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom % 40) == 0, $urandom % 2, 2'($urandom % 4),
                    ($urandom % 10) == 0);
    end
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pipeline_step_ctrl.md
# pipeline_step_ctrl

Sequencing controller for the MIPS pipeline's debug execution modes. It generates the single `o_step` enable consumed by every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC. It accepts run, step and stop commands from the debug unit. When a HALT instruction is fetched, it drains the pipeline so every instruction ahead of HALT retires, then parks in a sticky DONE state.

## Interface

Parameters:
- `PIPE_DEPTH`, default 4: number of drain step cycles after HALT is sampled; must be ≥1.
- `NB_CYCLE`, default 32: width of the step-cycle counter.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_cmd_valid`, in, 1: command strobe.
- `i_cmd`, in, 2: command code. 00 NOP, 01 RUN, 10 STEP, 11 STOP.
- `o_cmd_ready`, out, 1: command is accepted on an edge where `i_cmd_valid & o_cmd_ready`.
- `i_halt`, in, 1: IF stage holds a HALT opcode. Sampled only in cycles where `o_step = 1`.
- `o_step`, out, 1: advance enable for all pipeline registers and the PC.
- `o_done`, out, 1: level, high in DONE.
- `o_state`, out, 3: current state encoding, for debug readout.
- `o_cycle_count`, out, NB_CYCLE: number of cycles in which `o_step` was high.

## Operation

- FSM states: IDLE, RUN, STEP, DRAIN, DONE. Outputs are Moore, decoded from the registered state.
- IDLE: `o_step=0`, `o_cmd_ready=1`.
  - Accepted RUN → RUN.
  - Accepted STEP → STEP.
  - NOP or STOP → stay in IDLE.
- RUN: `o_step=1`, `o_cmd_ready=1`.
  - `i_halt=1` → DRAIN.
  - Else accepted STOP → IDLE.
  - RUN, STEP and NOP are accepted with no effect.
  - HALT wins over a simultaneous STOP.
- STEP: `o_step=1` for exactly one cycle, `o_cmd_ready=0`.
  - Next state is DRAIN if `i_halt=1`, else IDLE.
- DRAIN: `o_step=1`, `o_cmd_ready=0`.
  - The drain counter loads `PIPE_DEPTH` on entry and decrements each cycle.
  - Leave for DONE in the cycle the counter equals 1, giving exactly `PIPE_DEPTH` DRAIN cycles.
  - `i_halt` is ignored.
- DONE: `o_step=0`, `o_done=1`, `o_cmd_ready=0`. Sticky; only `i_reset` exits.
- Drain counter width: `$clog2(PIPE_DEPTH+1)`. It never wraps.
- Cycle counter:
  - +1 on every edge where `o_step=1`.
  - Saturates at `2^NB_CYCLE-1`.
  - Not cleared by STOP or DONE.
- Reset values: state IDLE, `o_step=0`, `o_cmd_ready=1`, `o_done=0`, `o_state=IDLE`, `o_cycle_count=0`, drain counter 0.

## Timing

- A command accepted at edge N drives `o_step` high from edge N to edge N+1. Command-to-step latency is 1 cycle.
- STOP accepted at edge N: `o_step=0` from edge N. No further step cycles occur after the STOP cycle.
- `i_halt` sampled high at edge N (in RUN or STEP) gives `PIPE_DEPTH` further `o_step` cycles, then DONE.
- Reset mid-operation (any state, including DRAIN): IDLE after that edge. Counters are cleared and `o_step` is low in the following cycle.
- Reset has priority over every command and over `i_halt`.

## Configuration

- `STEP_CYCLE_COUNTER_EN`:
  - Defined: the cycle counter is built and `o_cycle_count` reports as described above.
  - Undefined: counter logic is removed and `o_cycle_count` is tied to 0. The port list is unchanged.

## Structure

- Shared package `mips_debug_pkg` holds:
  - the state enum (IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4);
  - command codes CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP.
- One sub-module, `step_cycle_counter`: a saturating counter with enable and synchronous reset. It is instantiated only under `STEP_CYCLE_COUNTER_EN`.
- FSM and drain counter stay in the top module.

## Test plan

All scenarios use `PIPE_DEPTH=4` unless noted.

1. Reset asserted for 2 cycles → `o_step=0`, `o_cmd_ready=1`, `o_done=0`, `o_state=0`, `o_cycle_count=0`.
2. One accepted STEP → `o_step` high exactly 1 cycle, then back to IDLE. `o_cycle_count=1`. A second STEP gives `o_cycle_count=2`.
3. Accepted RUN, then STOP accepted 10 cycles later → exactly 10 `o_step` cycles, `o_cycle_count=10`, IDLE.
4. RUN with `i_halt` high in the 5th step cycle, simultaneous with STOP → DRAIN (HALT wins). Then 4 more step cycles, DONE, `o_done=1`, `o_cycle_count=9`. Later RUN commands are ignored.
5. Reset pulse in the 2nd DRAIN cycle → IDLE, `o_step=0` next cycle, `o_cycle_count=0`, `o_done=0`.
6. With `NB_CYCLE=4`, RUN for 20 cycles → `o_cycle_count` holds at 15. With the macro undefined → stays 0 throughout.
